// File: rtl/rgb_pwm_wheel_if.sv
// rgb_pwm_wheel_if: control and status bundle of the RGB colour-wheel PWM driver.
//   enable_i     run (1) / freeze with LEDs off (0)
//   step_div_i   fade step every step_div_i+1 PWM periods
//   LED_x_n_o    registered LED pins, polarity set by the driver's ACTIVE_LOW
//   phase_o      current wheel state
//   wrap_o       one-clock pulse after each completed wheel cycle
// master: the controller side (drives enable/step, observes pins and status).
// slave:  the driver block itself.
interface rgb_pwm_wheel_if #(
  parameter int DIV_W = 16
);
  logic             enable_i;
  logic [DIV_W-1:0] step_div_i;
  logic             LED_R_n_o;
  logic             LED_G_n_o;
  logic             LED_B_n_o;
  logic [2:0]       phase_o;
  logic             wrap_o;

  modport master (
    output enable_i, step_div_i,
    input  LED_R_n_o, LED_G_n_o, LED_B_n_o, phase_o, wrap_o
  );

  modport slave (
    input  enable_i, step_div_i,
    output LED_R_n_o, LED_G_n_o, LED_B_n_o, phase_o, wrap_o
  );
endinterface

// File: rtl/rgb_pwm_wheel.sv
// rgb_pwm_wheel: RGB colour-wheel PWM driver.
// A free-running PWM_W-bit counter sets the PWM period (2^PWM_W clocks). A
// divider counts PWM periods and issues a fade tick every step_div_i+1 periods;
// each tick moves one channel duty one step along the wheel
//   S_INIT(R+) -> G_UP -> R_DN -> B_UP -> G_DN -> R_UP -> B_DN -> G_UP ...
// Ticks only occur on the last clock of a PWM period, so no period is glitched.
// Ports:
//   clk_24MHz_i  sole clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   bus          rgb_pwm_wheel_if.slave (enable, step divider, LED pins, status)
// Build option:
//   RGB_PWM_GAMMA_EN  defined: quadratic gamma (duty*duty >> PWM_W, full scale kept)
//                     on each channel before the compare; undefined: duty used as-is.

// One PWM channel: duty shaping, compare and registered pin.
module rgb_pwm_lane #(
  parameter int PWM_W      = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk_24MHz_i,
  input  logic             rst_n_i,
  input  logic             enable_i,
  input  logic [PWM_W-1:0] pwm_cnt,
  input  logic [PWM_W-1:0] duty,
  output logic             pin_n
);
  localparam logic AL = (ACTIVE_LOW != 0);

  logic [PWM_W-1:0] duty_eff;
  logic             on;

`ifdef RGB_PWM_GAMMA_EN
  logic [2*PWM_W-1:0] duty_x;
  logic [2*PWM_W-1:0] duty_sq;
  assign duty_x  = {{PWM_W{1'b0}}, duty};
  assign duty_sq = duty_x * duty_x;
  // full scale is pinned so max duty stays max after the squash
  assign duty_eff = (duty == {PWM_W{1'b1}}) ? duty : duty_sq[2*PWM_W-1:PWM_W];
`else
  assign duty_eff = duty;
`endif

  assign on = enable_i & (pwm_cnt < duty_eff);

  always_ff @(posedge clk_24MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) pin_n <= AL;
    else          pin_n <= on ^ AL;
  end
endmodule

module rgb_pwm_wheel #(
  parameter int PWM_W      = 8,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 1
) (
  input  logic           clk_24MHz_i,
  input  logic           rst_n_i,
  rgb_pwm_wheel_if.slave bus
);
  localparam int NUM_CH = 3;  // 0 = R, 1 = G, 2 = B
  localparam logic [PWM_W-1:0] DUTY_MAX = {PWM_W{1'b1}};

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    G_UP   = 3'd1,
    R_DN   = 3'd2,
    B_UP   = 3'd3,
    G_DN   = 3'd4,
    R_UP   = 3'd5,
    B_DN   = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  state_t                        state_q, state_d;
  logic [NUM_CH-1:0][PWM_W-1:0]  duty_q, duty_d;
  logic                          wrap_q, wrap_d;
  logic [PWM_W-1:0]              pwm_cnt;
  logic [DIV_W-1:0]              div_cnt;
  logic [NUM_CH-1:0]             pin_n;
  logic                          pwm_wrap;
  logic                          div_hit;
  logic                          tick;

  // ---------------- PWM period and fade divider ----------------
  assign pwm_wrap = (pwm_cnt == DUTY_MAX);
  // '>=' so that lowering step_div_i mid-count fires on the next wrap
  // instead of running the divider all the way round
  assign div_hit  = (div_cnt >= bus.step_div_i);
  assign tick     = bus.enable_i & pwm_wrap & div_hit;

  always_ff @(posedge clk_24MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + PWM_W'(1);
  end

  always_ff @(posedge clk_24MHz_i or negedge rst_n_i) begin
    if (!rst_n_i)             div_cnt <= '0;
    else if (!bus.enable_i)   div_cnt <= '0;
    else if (pwm_wrap) begin
      if (div_hit)            div_cnt <= '0;
      else                    div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // ---------------- wheel state machine ----------------
  always_ff @(posedge clk_24MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_INIT;
      duty_q  <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      wrap_q  <= wrap_d;
    end
  end

  logic [1:0] ch;      // channel ramped in the current state
  logic       up;      // ramp direction
  logic       bad;     // unused encoding
  state_t     nxt;     // state after the ramp completes
  logic       at_lim;

  always_comb begin
    ch  = 2'd0;
    up  = 1'b1;
    bad = 1'b0;
    nxt = S_INIT;
    case (state_q)
      S_INIT: begin ch = 2'd0; up = 1'b1; nxt = G_UP; end
      G_UP:   begin ch = 2'd1; up = 1'b1; nxt = R_DN; end
      R_DN:   begin ch = 2'd0; up = 1'b0; nxt = B_UP; end
      B_UP:   begin ch = 2'd2; up = 1'b1; nxt = G_DN; end
      G_DN:   begin ch = 2'd1; up = 1'b0; nxt = R_UP; end
      R_UP:   begin ch = 2'd0; up = 1'b1; nxt = B_DN; end
      B_DN:   begin ch = 2'd2; up = 1'b0; nxt = G_UP; end
      default: bad = 1'b1;
    endcase
  end

  assign at_lim = up ? (duty_q[ch] == DUTY_MAX) : (duty_q[ch] == '0);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    wrap_d  = 1'b0;
    if (bad) begin
      // stray encoding: restart the wheel cleanly without waiting for a tick
      state_d = S_INIT;
      duty_d  = '0;
    end else if (tick) begin
      if (at_lim) begin
        // the tick at the ramp limit is the transition tick
        state_d = nxt;
        wrap_d  = (state_q == B_DN);
      end else if (up) begin
        duty_d[ch] = duty_q[ch] + PWM_W'(1);
      end else begin
        duty_d[ch] = duty_q[ch] - PWM_W'(1);
      end
    end
  end

  // ---------------- channel lanes ----------------
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rgb_pwm_lane #(
      .PWM_W      (PWM_W),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_lane (
      .clk_24MHz_i (clk_24MHz_i),
      .rst_n_i     (rst_n_i),
      .enable_i    (bus.enable_i),
      .pwm_cnt     (pwm_cnt),
      .duty        (duty_q[g]),
      .pin_n       (pin_n[g])
    );
  end

  assign bus.LED_R_n_o = pin_n[0];
  assign bus.LED_G_n_o = pin_n[1];
  assign bus.LED_B_n_o = pin_n[2];
  assign bus.phase_o   = state_q;
  assign bus.wrap_o    = wrap_q;
endmodule
